motion_bbox_tracker: RTL and testbench
======================================

Name: motion_bbox_tracker

Overview:
- Downstream of the motion-detection stage. Consumes its per-pixel binary motion stream (E = 0/255, reduced to a 1-bit flag) in raster order.
- Rejects isolated noise with a horizontal run-length filter.
- Accumulates a per-frame bounding box of motion and publishes it, with hold/clear logic, to the VGA overlay / pan-tilt logic at each frame end.

Parameters:
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- RUN_MIN, 3, consecutive motion pixels on one line needed before a run is accepted (1..15)
- MIN_COUNT, 64, accepted pixels per frame needed to publish a valid box
- HOLD_FRAMES, 4, consecutive empty frames tolerated before the box is cleared (1..15)

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  async active-low reset
- pix_valid  in  1  one pixel presented this cycle
- pix_motion  in  1  motion flag for the pixel (E != 0)
- pix_sof  in  1  with pix_valid: this pixel is (0,0); resynchronises counters
- frame_done  out  1  one-cycle pulse after the last pixel of a frame
- box_valid  out  1  published box is meaningful
- box_x_min  out  10  published left edge
- box_x_max  out  10  published right edge
- box_y_min  out  10  published top edge
- box_y_max  out  10  published bottom edge
- box_cx  out  10  (box_x_min + box_x_max) >> 1, registered
- box_cy  out  10  (box_y_min + box_y_max) >> 1, registered
- motion_count  out  19  accepted-pixel count of the last completed frame, saturating

Behaviour:
- Reset: clk, rst_n (asynchronous, active-low). All outputs 0; x/y counters 0; accumulators in the empty state (min = all-ones, max = 0, count = 0); run_len 0; miss counter 0.
- Counters:
  - x/y advance only on pix_valid; x wraps at IMG_W-1 and increments y.
  - Position (IMG_W-1, IMG_H-1) is the last pixel of the frame; counters then return to (0,0).
  - pix_valid low: nothing changes.
- Run filter:
  - On a motion pixel, run_len increments, saturating at 15. When run_len was 0, run_start_x latches x.
  - On a non-motion pixel, or after the last pixel of a line, run_len returns to 0. Runs never span lines.
  - A pixel is accepted when its incremented run_len >= RUN_MIN.
- Accumulation (on an accepted pixel):
  - x_min = min(x_min, run_start_x); x_max = max(x_max, x); y_min = min(y_min, y); y_max = max(y_max, y).
  - count += 1, saturating at 2^19-1.
- Frame end: the cycle after the last pixel is accepted, frame_done pulses for exactly one cycle and the published registers update in that same cycle.
  - If count >= MIN_COUNT: publish the accumulated box, box_valid = 1, miss counter = 0.
  - Else: miss counter increments. While it is below HOLD_FRAMES, keep the previous box and box_valid. When it reaches HOLD_FRAMES, box_valid = 0 and the box is zeroed.
  - motion_count = count in every case.
  - box_cx/box_cy update one cycle after the box (latency 2 from the last pixel).
  - Accumulators and run_len are re-emptied in the same cycle as the last pixel, so the next frame may start back-to-back.
- pix_sof:
  - With pix_valid: that pixel is processed as (0,0).
  - If counters were not already at (0,0), the partial frame is discarded: accumulators are cleared before this pixel is applied, no frame_done, published outputs unchanged.
- Simultaneous events: pix_sof on the cycle after the last pixel is the normal case, with no discard. The frame_done cycle accepts a new pixel normally.
- Mid-frame reset: everything returns to reset values. The first frame after reset is only trusted if it starts with pix_sof or counters are at (0,0).

Optional Feature:
- MOTION_BBOX_SMOOTH_EN defined:
  - Each published edge becomes e_new = e_old + ((raw - e_old) >>> 2), arithmetic on 11-bit signed.
  - When box_valid rises from 0, the raw box is loaded directly, with no smoothing.
  - Adds no latency; the smoothing is applied in the frame_done cycle.
- Not defined: raw box published directly.

Decomposition:
- Package motion_pkg:
  - IMG_W/IMG_H defaults and COORD_W = 10.
  - Typedef bbox_t {x_min, x_max, y_min, y_max}.
  - Constant BBOX_EMPTY.
- Sub-module motion_run_filter:
  - Holds run_len, run_start_x and line-end clear.
  - Outputs accept and run_start_x.

Test Plan (IMG_W=8, IMG_H=4, RUN_MIN=3, MIN_COUNT=2, HOLD_FRAMES=2 unless noted):
- Line 1, x=2..5 motion; rest 0 -> accepted x=4,5; frame_done one cycle after (7,3); box (2,5,1,1), box_valid=1, motion_count=2, cx=3, cy=1 one cycle later.
- Isolated motion pixels at x=1, x=3 and pair x=5,6 on all lines -> no acceptance; box_valid stays 0, motion_count=0.
- Run x=6,7 on line 0 continuing x=0 on line 1 -> run cleared at line end, count 0.
- Valid frame, then two empty frames -> box held after the first empty frame, box_valid=0 and box=0 after the second.
- pix_sof mid-frame at (3,2) after motion pixels -> no frame_done, outputs unchanged; the next full frame publishes only its own box.
- MOTION_BBOX_SMOOTH_EN, previous x_max=40, raw 80 (IMG_W=640 run) -> x_max=50; pix_valid gaps mid-frame do not change results.

Source files
------------

// File: rtl/motion_bbox_tracker_pkg.sv
// ============================================================================
// Package : motion_pkg
// Brief   : Shared widths, bounding-box type and edge-smoothing helpers for
//           the motion bounding-box tracker.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package motion_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int COORD_W   = 10;
    localparam int CNT_W     = 19;
    localparam int RUN_W     = 4;

    typedef struct packed {
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
    } bbox_t;

    // Empty box: mins at all-ones, maxes at zero, so the first accepted pixel wins both
    localparam bbox_t BBOX_EMPTY = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0};

    function automatic logic [COORD_W-1:0] smooth_edge(input logic [COORD_W-1:0] e_old,
                                                       input logic [COORD_W-1:0] raw);
        logic signed [COORD_W:0] diff;
        logic signed [COORD_W:0] sum;
        diff = $signed({1'b0, raw}) - $signed({1'b0, e_old});
        sum  = $signed({1'b0, e_old}) + (diff >>> 2);
        return sum[COORD_W-1:0];
    endfunction

    function automatic bbox_t smooth_box(input bbox_t b_old, input bbox_t b_raw);
        bbox_t b;
        b.x_min = smooth_edge(b_old.x_min, b_raw.x_min);
        b.x_max = smooth_edge(b_old.x_max, b_raw.x_max);
        b.y_min = smooth_edge(b_old.y_min, b_raw.y_min);
        b.y_max = smooth_edge(b_old.y_max, b_raw.y_max);
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/motion_bbox_tracker_if.sv
// ============================================================================
// Interface : motion_bbox_tracker_if
// Brief     : Pixel-stream input and published-box output bundle.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface motion_bbox_tracker_if
    import motion_pkg::*;
();

    logic               pix_valid;
    logic               pix_motion;
    logic               pix_sof;
    logic               frame_done;
    logic               box_valid;
    logic [COORD_W-1:0] box_x_min;
    logic [COORD_W-1:0] box_x_max;
    logic [COORD_W-1:0] box_y_min;
    logic [COORD_W-1:0] box_y_max;
    logic [COORD_W-1:0] box_cx;
    logic [COORD_W-1:0] box_cy;
    logic [CNT_W-1:0]   motion_count;

    modport master (
        output pix_valid, pix_motion, pix_sof,
        input  frame_done, box_valid, box_x_min, box_x_max, box_y_min, box_y_max,
               box_cx, box_cy, motion_count
    );

    modport slave (
        input  pix_valid, pix_motion, pix_sof,
        output frame_done, box_valid, box_x_min, box_x_max, box_y_min, box_y_max,
               box_cx, box_cy, motion_count
    );

endinterface

`default_nettype wire

// File: rtl/motion_bbox_tracker_run_filter.sv
// ============================================================================
// Module : motion_run_filter
// Brief  : Horizontal run-length noise filter; accepts a motion pixel once its
//          run on the current line reaches RUN_MIN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motion_run_filter
    import motion_pkg::*;
#(
    parameter int RUN_MIN = 3
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               valid,
    input  wire logic               motion,
    input  wire logic               restart,
    input  wire logic               line_end,
    input  wire logic [COORD_W-1:0] x,
    output logic                    accept,
    output logic [COORD_W-1:0]      run_start_x
);

    localparam logic [RUN_W-1:0] c_RUN_MAX = '1;
    localparam logic [RUN_W-1:0] c_RUN_MIN = RUN_W'(RUN_MIN);

    logic [RUN_W-1:0]   r_run_len;
    logic [COORD_W-1:0] r_run_start_x;
    logic [RUN_W-1:0]   w_len_cur;
    logic [RUN_W-1:0]   w_len_inc;

    // A restart (start of frame) behaves as if no run were in progress
    always_comb begin
        w_len_cur   = restart ? '0 : r_run_len;
        w_len_inc   = (w_len_cur == c_RUN_MAX) ? w_len_cur : w_len_cur + RUN_W'(1);
        accept      = valid && motion && (w_len_inc >= c_RUN_MIN);
        run_start_x = (w_len_cur == '0) ? x : r_run_start_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_len     <= '0;
            r_run_start_x <= '0;
        end else if (valid) begin
            r_run_len <= (motion && !line_end) ? w_len_inc : '0;
            if (motion && (w_len_cur == '0)) begin
                r_run_start_x <= x;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/motion_bbox_tracker.sv
// ============================================================================
// Module : motion_bbox_tracker
// Brief  : Per-frame bounding box of filtered motion pixels with hold/clear.
// Macro  : MOTION_BBOX_SMOOTH_EN - low-pass filter published edges (1/4 step).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motion_bbox_tracker
    import motion_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int RUN_MIN     = 3,
    parameter int MIN_COUNT   = 64,
    parameter int HOLD_FRAMES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    motion_bbox_tracker_if.slave  bus
);

    localparam logic [COORD_W-1:0] c_X_LAST    = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] c_Y_LAST    = COORD_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0]   c_MIN_COUNT = CNT_W'(MIN_COUNT);
    localparam logic [RUN_W:0]     c_HOLD      = (RUN_W+1)'(HOLD_FRAMES);

    logic [COORD_W-1:0] r_x, r_y;
    bbox_t              r_acc;
    logic [CNT_W-1:0]   r_count;
    bbox_t              r_box;
    logic               r_box_valid;
    logic [RUN_W-1:0]   r_miss;
    logic               r_frame_done;
    logic [CNT_W-1:0]   r_motion_count;
    logic [COORD_W-1:0] r_cx, r_cy;

    logic [COORD_W-1:0] w_x, w_y;
    logic               w_discard;
    logic               w_line_end;
    logic               w_last;
    logic               w_accept;
    logic [COORD_W-1:0] w_run_start_x;
    bbox_t              w_acc_next;
    logic [CNT_W-1:0]   w_cnt_next;
    bbox_t              w_pub_box;
    logic [RUN_W:0]     w_miss_inc;
    logic [COORD_W:0]   w_sum_x, w_sum_y;

    // pix_sof forces this pixel to (0,0); a non-origin position means a partial frame
    always_comb begin
        w_x        = bus.pix_sof ? '0 : r_x;
        w_y        = bus.pix_sof ? '0 : r_y;
        w_discard  = bus.pix_sof && ((r_x != '0) || (r_y != '0));
        w_line_end = (w_x == c_X_LAST);
        w_last     = w_line_end && (w_y == c_Y_LAST);
    end

    motion_run_filter #(
        .RUN_MIN     (RUN_MIN)
    ) u_run_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (bus.pix_valid),
        .motion      (bus.pix_motion),
        .restart     (bus.pix_sof),
        .line_end    (w_line_end),
        .x           (w_x),
        .accept      (w_accept),
        .run_start_x (w_run_start_x)
    );

    always_comb begin
        w_acc_next = w_discard ? BBOX_EMPTY : r_acc;
        w_cnt_next = w_discard ? '0 : r_count;
        if (w_accept) begin
            if (w_run_start_x < w_acc_next.x_min) w_acc_next.x_min = w_run_start_x;
            if (w_x > w_acc_next.x_max)           w_acc_next.x_max = w_x;
            if (w_y < w_acc_next.y_min)           w_acc_next.y_min = w_y;
            if (w_y > w_acc_next.y_max)           w_acc_next.y_max = w_y;
            if (w_cnt_next != '1)                 w_cnt_next = w_cnt_next + CNT_W'(1);
        end
        w_miss_inc = {1'b0, r_miss} + (RUN_W+1)'(1);
    end

`ifdef MOTION_BBOX_SMOOTH_EN
    // Fresh boxes load raw so the filter does not crawl in from zero
    always_comb begin
        w_pub_box = r_box_valid ? smooth_box(r_box, w_acc_next) : w_acc_next;
    end
`else
    always_comb begin
        w_pub_box = w_acc_next;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x            <= '0;
            r_y            <= '0;
            r_acc          <= BBOX_EMPTY;
            r_count        <= '0;
            r_box          <= '0;
            r_box_valid    <= 1'b0;
            r_miss         <= '0;
            r_frame_done   <= 1'b0;
            r_motion_count <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (bus.pix_valid) begin
                if (w_line_end) begin
                    r_x <= '0;
                    r_y <= (w_y == c_Y_LAST) ? '0 : w_y + COORD_W'(1);
                end else begin
                    r_x <= w_x + COORD_W'(1);
                    r_y <= w_y;
                end
                if (w_last) begin
                    r_frame_done   <= 1'b1;
                    r_acc          <= BBOX_EMPTY;
                    r_count        <= '0;
                    r_motion_count <= w_cnt_next;
                    if (w_cnt_next >= c_MIN_COUNT) begin
                        r_box       <= w_pub_box;
                        r_box_valid <= 1'b1;
                        r_miss      <= '0;
                    end else if (w_miss_inc >= c_HOLD) begin
                        r_box       <= '0;
                        r_box_valid <= 1'b0;
                        r_miss      <= c_HOLD[RUN_W-1:0];
                    end else begin
                        r_miss      <= w_miss_inc[RUN_W-1:0];
                    end
                end else begin
                    r_acc   <= w_acc_next;
                    r_count <= w_cnt_next;
                end
            end
        end
    end

    assign w_sum_x = {1'b0, r_box.x_min} + {1'b0, r_box.x_max};
    assign w_sum_y = {1'b0, r_box.y_min} + {1'b0, r_box.y_max};

    // Centre trails the box by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx <= '0;
            r_cy <= '0;
        end else begin
            r_cx <= w_sum_x[COORD_W:1];
            r_cy <= w_sum_y[COORD_W:1];
        end
    end

    assign bus.frame_done   = r_frame_done;
    assign bus.box_valid    = r_box_valid;
    assign bus.box_x_min    = r_box.x_min;
    assign bus.box_x_max    = r_box.x_max;
    assign bus.box_y_min    = r_box.y_min;
    assign bus.box_y_max    = r_box.y_max;
    assign bus.box_cx       = r_cx;
    assign bus.box_cy       = r_cy;
    assign bus.motion_count = r_motion_count;

endmodule

`default_nettype wire

// File: tb/tb_motion_bbox_tracker.sv
// ============================================================================
// Module : tb_motion_bbox_tracker
// Brief  : Directed frame-level bench for motion_bbox_tracker (8x4 image).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_motion_bbox_tracker;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int RMIN = 3;
    localparam int MINC = 2;
    localparam int HOLD = 2;

    typedef struct {
        int v;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    motion_bbox_tracker_if bus ();

    motion_bbox_tracker #(
        .IMG_W       (W),
        .IMG_H       (H),
        .RUN_MIN     (RMIN),
        .MIN_COUNT   (MINC),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    logic [W-1:0] mask [H];
    bit   seen_fd;

    // Reference model state for the published box
    int m_v = 0, m_xmin = 0, m_xmax = 0, m_ymin = 0, m_ymax = 0, m_miss = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mask();
        for (int y = 0; y < H; y++) mask[y] = '0;
    endtask

    task automatic model_frame();
        int cnt, xmin, xmax, ymin, ymax, run, start;
        exp_t e;
        cnt = 0; xmin = 1023; xmax = 0; ymin = 1023; ymax = 0;
        for (int y = 0; y < H; y++) begin
            run = 0; start = 0;
            for (int x = 0; x < W; x++) begin
                if (mask[y][x]) begin
                    if (run == 0) start = x;
                    if (run < 15) run++;
                    if (run >= RMIN) begin
                        cnt++;
                        if (start < xmin) xmin = start;
                        if (x > xmax) xmax = x;
                        if (y < ymin) ymin = y;
                        if (y > ymax) ymax = y;
                    end
                end else begin
                    run = 0;
                end
            end
        end
        if (cnt >= MINC) begin
            m_v = 1; m_xmin = xmin; m_xmax = xmax; m_ymin = ymin; m_ymax = ymax; m_miss = 0;
        end else begin
            m_miss++;
            if (m_miss >= HOLD) begin
                m_v = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0; m_miss = HOLD;
            end
        end
        e = '{v: m_v, xmin: m_xmin, xmax: m_xmax, ymin: m_ymin, ymax: m_ymax, cnt: cnt};
        sb.push_back(e);
    endtask

    task automatic drive_pix(input logic m, input logic s);
        bus.pix_valid  = 1'b1;
        bus.pix_motion = m;
        bus.pix_sof    = s;
        @(posedge clk);
        #1;
        bus.pix_valid  = 1'b0;
        bus.pix_motion = 1'b0;
        bus.pix_sof    = 1'b0;
        seen_fd        = seen_fd | bus.frame_done;
    endtask

    task automatic idle_cycle();
        bus.pix_motion = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        bus.pix_motion = 1'b0;
    endtask

    // Drive a whole frame from (0,0) with pix_sof; frame_done is visible on return
    task automatic drive_frame(input bit gaps);
        model_frame();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (gaps && ($urandom_range(0, 2) == 0)) idle_cycle();
                drive_pix(mask[y][x], (x == 0) && (y == 0));
            end
        end
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, ".frame_done"},   32'(bus.frame_done),   1);
        check({tag, ".box_valid"},    32'(bus.box_valid),    e.v);
        check({tag, ".x_min"},        32'(bus.box_x_min),    e.xmin);
        check({tag, ".x_max"},        32'(bus.box_x_max),    e.xmax);
        check({tag, ".y_min"},        32'(bus.box_y_min),    e.ymin);
        check({tag, ".y_max"},        32'(bus.box_y_max),    e.ymax);
        check({tag, ".motion_count"}, 32'(bus.motion_count), e.cnt);
        @(posedge clk);
        #1;
        check({tag, ".fd_pulse_end"}, 32'(bus.frame_done),   0);
        check({tag, ".cx"},           32'(bus.box_cx),       (e.xmin + e.xmax) >> 1);
        check({tag, ".cy"},           32'(bus.box_cy),       (e.ymin + e.ymax) >> 1);
    endtask

    initial begin
        bus.pix_valid  = 1'b0;
        bus.pix_motion = 1'b0;
        bus.pix_sof    = 1'b0;
        seen_fd        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.frame_done",   32'(bus.frame_done),   0);
        check("rst.box_valid",    32'(bus.box_valid),    0);
        check("rst.x_min",        32'(bus.box_x_min),    0);
        check("rst.x_max",        32'(bus.box_x_max),    0);
        check("rst.cx",           32'(bus.box_cx),       0);
        check("rst.motion_count", 32'(bus.motion_count), 0);

        // Isolated pixels and a pair: below RUN_MIN everywhere
        clear_mask();
        for (int y = 0; y < H; y++) mask[y] = 8'b0110_1010;
        drive_frame(1'b0);
        check_frame("isolated");

        // Run of 2 at the end of line 0 must not carry into line 1
        clear_mask();
        mask[0] = 8'b1100_0000;
        mask[1] = 8'b0000_0001;
        drive_frame(1'b0);
        check_frame("line_wrap");

        // Line 1, x=2..5: accepted x=4,5 -> box (2,5,1,1)
        clear_mask();
        mask[1] = 8'b0011_1100;
        drive_frame(1'b0);
        check_frame("basic");

        // Two empty frames: hold then clear
        clear_mask();
        drive_frame(1'b0);
        check_frame("hold1");
        drive_frame(1'b0);
        check_frame("hold2");

        // Valid frame, then a partial frame restarted by pix_sof at (3,2)
        clear_mask();
        mask[0] = 8'b0111_1110;
        mask[2] = 8'b1111_1000;
        drive_frame(1'b0);
        check_frame("pre_sof");
        seen_fd = 1'b0;
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < W; x++) begin
                if (!((y == 2) && (x >= 3))) drive_pix(1'b1, (x == 0) && (y == 0));
            end
        end
        check("sof.no_frame_done", 32'(seen_fd),           0);
        check("sof.hold_valid",    32'(bus.box_valid),     m_v);
        check("sof.hold_x_min",    32'(bus.box_x_min),     m_xmin);
        check("sof.hold_y_max",    32'(bus.box_y_max),     m_ymax);
        clear_mask();
        mask[3] = 8'b1111_0000;
        drive_frame(1'b0);
        check_frame("post_sof");

        // Same content with random pix_valid gaps
        clear_mask();
        mask[1] = 8'b1111_1110;
        mask[2] = 8'b0011_1111;
        mask[3] = 8'b0000_0111;
        drive_frame(1'b0);
        check_frame("nogap");
        drive_frame(1'b1);
        check_frame("gaps");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
